// File: rtl/tx_sched_pkg.sv
// Shared constants, state encoding and limit tables for the TX send scheduler.
package tx_sched_pkg;

  localparam int unsigned CntW              = 27;
  localparam int unsigned GapW              = 17;
  localparam int unsigned CopyW             = 3;
  localparam int unsigned AckW              = 8;
  localparam int unsigned WrapAddrDefault   = 57600;
  localparam int unsigned AckTimeoutDefault = 15;

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StIssue,
    StWaitAck,
    StWaitDone
  } state_e;

  // Terminal count of the period counter: 125 MHz / rate - 1.
  function automatic logic [CntW-1:0] rate_limit(input logic [3:0] sel);
    logic [CntW-1:0] lim;
    case (sel)
      4'd0:    lim = 27'd124999999;
      4'd1:    lim = 27'd62499999;
      4'd2:    lim = 27'd12499999;
      4'd3:    lim = 27'd6249999;
      4'd4:    lim = 27'd2499999;
      4'd5:    lim = 27'd1249999;
      4'd6:    lim = 27'd624999;
      4'd7:    lim = 27'd249999;
      4'd8:    lim = 27'd124999;
      4'd9:    lim = 27'd62499;
      4'd10:   lim = 27'd24999;
      4'd11:   lim = 27'd12499;
      4'd12:   lim = 27'd6249;
      4'd13:   lim = 27'd2499;
      4'd14:   lim = 27'd1249;
      default: lim = 27'd30;
    endcase
    return lim;
  endfunction

  function automatic logic [GapW-1:0] gap_limit(input logic [1:0] sel);
    logic [GapW-1:0] lim;
    case (sel)
      2'd0:    lim = 17'd30;
      2'd1:    lim = 17'd1249;
      2'd2:    lim = 17'd12499;
      default: lim = 17'd124999;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/tx_rate_table.sv
// Registered lookup of the period and inter-copy gap limits.
module tx_rate_table
  import tx_sched_pkg::*;
(
  input  logic            clk,
  input  logic [3:0]      rate_sel,
  input  logic [1:0]      gap_sel,
  output logic [CntW-1:0] max_count,
  output logic [GapW-1:0] max_gap
);

  // Pure pipeline register; it reloads every cycle, including during reset.
  always_ff @(posedge clk) begin
    max_count <= rate_limit(rate_sel);
    max_gap   <= gap_limit(gap_sel);
  end

endmodule

// File: rtl/tx_send_scheduler.sv
// Periodic burst scheduler: issues N start pulses per period to a frame generator,
// spacing copies by a selectable gap and flagging overruns and missing acknowledges.
module tx_send_scheduler
  import tx_sched_pkg::*;
#(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WRAP_ADDR   = WrapAddrDefault,
  parameter int unsigned ACK_TIMEOUT = AckTimeoutDefault
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              enable,
  input  logic [3:0]        rate_sel,
  input  logic [1:0]        gap_sel,
  input  logic [2:0]        redundancy,
  input  logic              busy,
  input  logic [ADDR_W-1:0] lastaddr,
  output logic              start_sending,
  output logic [ADDR_W-1:0] startaddr,
  output logic [7:0]        txid,
  output logic              in_sending,
  output logic              burst_done,
  output logic              overrun,
  output logic              ack_err
);

  localparam logic [ADDR_W-1:0] WrapAt  = ADDR_W'(WRAP_ADDR);
  localparam logic [AckW-1:0]   AckLast = AckW'(ACK_TIMEOUT - 1);

  logic [CntW-1:0]  max_count;
  logic [CntW-1:0]  period_cnt;
  logic [GapW-1:0]  max_gap;
  logic [GapW-1:0]  gap_cnt;
  logic             expire;
  logic [CopyW-1:0] copy_cnt;
  logic [CopyW-1:0] copy_total;
  logic [AckW-1:0]  ack_cnt;
  logic             copy_end;
  state_e           state;

  tx_rate_table u_rate_table (
    .clk       (clk),
    .rate_sel  (rate_sel),
    .gap_sel   (gap_sel),
    .max_count (max_count),
    .max_gap   (max_gap)
  );

  // >= so a shrinking rate selection wraps at once instead of rolling the full counter.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      period_cnt <= '0;
      expire     <= 1'b0;
    end else if (period_cnt >= max_count) begin
      period_cnt <= '0;
      expire     <= 1'b1;
    end else begin
      period_cnt <= period_cnt + CntW'(1);
      expire     <= 1'b0;
    end
  end

  // A copy is finished either by busy falling or by the acknowledge timeout.
  assign copy_end = ((state == StWaitDone) && !busy) ||
                    ((state == StWaitAck) && !busy && (ack_cnt == AckLast));

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state         <= StIdle;
      gap_cnt       <= '0;
      copy_cnt      <= '0;
      copy_total    <= '0;
      ack_cnt       <= '0;
      start_sending <= 1'b0;
      startaddr     <= '0;
      txid          <= '0;
      in_sending    <= 1'b0;
      burst_done    <= 1'b0;
      overrun       <= 1'b0;
      ack_err       <= 1'b0;
    end else begin
      start_sending <= 1'b0;
      burst_done    <= 1'b0;
      overrun       <= 1'b0;
      ack_err       <= 1'b0;

      if (expire && (state != StIdle)) overrun <= 1'b1;

      case (state)
        StIdle: begin
          if (expire && enable && !busy) begin
            copy_total <= (redundancy == 3'd0) ? 3'd1 : redundancy;
            startaddr  <= (lastaddr >= WrapAt) ? '0 : lastaddr;
            copy_cnt   <= '0;
            gap_cnt    <= '0;
            in_sending <= 1'b1;
            state      <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt < max_gap) gap_cnt <= gap_cnt + GapW'(1);
          if ((gap_cnt >= max_gap) && !busy) state <= StIssue;
        end
        StIssue: begin
          start_sending <= 1'b1;
          copy_cnt      <= copy_cnt + CopyW'(1);
          txid          <= 8'(copy_cnt) + 8'd1;
          ack_cnt       <= '0;
          state         <= StWaitAck;
        end
        StWaitAck: begin
          ack_cnt <= ack_cnt + AckW'(1);
          if (busy) begin
            state <= StWaitDone;
          end else if (ack_cnt == AckLast) begin
            ack_err <= 1'b1;
          end
        end
        StWaitDone: ;
        default: state <= StIdle;
      endcase

      if (copy_end) begin
        if (copy_cnt == copy_total) begin
          state      <= StIdle;
          in_sending <= 1'b0;
          burst_done <= 1'b1;
        end else begin
          gap_cnt <= '0;
          state   <= StGap;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_send_scheduler.sv
// Self-checking bench: the bench plays the frame generator and checks each burst
// against counts, addresses and spacings computed from the scheduling rules.
module tb_tx_send_scheduler;

  localparam int unsigned AddrW  = 20;
  localparam int          Wrap   = 57600;
  localparam int          AckTo  = 15;
  localparam int          Period = 31;  // rate_sel 15 -> 30 + 1

  logic             clk = 1'b0;
  logic             rstb;
  logic             enable;
  logic [3:0]       rate_sel;
  logic [1:0]       gap_sel;
  logic [2:0]       redundancy;
  logic             busy;
  logic [AddrW-1:0] lastaddr;
  logic             start_sending;
  logic [AddrW-1:0] startaddr;
  logic [7:0]       txid;
  logic             in_sending;
  logic             burst_done;
  logic             overrun;
  logic             ack_err;

  always #4 clk = ~clk;

  tx_send_scheduler dut (
    .clk           (clk),
    .rstb          (rstb),
    .enable        (enable),
    .rate_sel      (rate_sel),
    .gap_sel       (gap_sel),
    .redundancy    (redundancy),
    .busy          (busy),
    .lastaddr      (lastaddr),
    .start_sending (start_sending),
    .startaddr     (startaddr),
    .txid          (txid),
    .in_sending    (in_sending),
    .burst_done    (burst_done),
    .overrun       (overrun),
    .ack_err       (ack_err)
  );

  int   checks;
  int   errors;
  int   c;
  int   start_t[$];
  int   txid_v[$];
  int   sa_v[$];
  int   done_t[$];
  int   ack_t[$];
  int   ovr_t[$];
  int   bfall_t[$];
  int   rise_t;
  int   fall_t;
  logic prev_ins;
  int   gen_h;
  int   busy_left;

  function automatic int gap_of(input int gs);
    case (gs)
      0:       return 30;
      1:       return 1249;
      2:       return 12499;
      default: return 124999;
    endcase
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input longint obs, input longint lo,
                           input longint hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One clock: sample outputs after the edge, log events, model the frame generator.
  task automatic tick();
    @(posedge clk);
    #1;
    c++;
    if (start_sending === 1'b1) begin
      start_t.push_back(c);
      txid_v.push_back(int'(txid));
      sa_v.push_back(int'(startaddr));
      if (gen_h > 0) begin
        busy      = 1'b1;
        busy_left = gen_h;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        busy = 1'b0;
        bfall_t.push_back(c);
      end
    end
    if (burst_done === 1'b1) done_t.push_back(c);
    if (ack_err === 1'b1) ack_t.push_back(c);
    if (overrun === 1'b1) ovr_t.push_back(c);
    if (in_sending === 1'b1 && prev_ins !== 1'b1) rise_t = c;
    if (in_sending !== 1'b1 && prev_ins === 1'b1) fall_t = c;
    prev_ins = in_sending;
  endtask

  task automatic clear_log();
    start_t.delete();
    txid_v.delete();
    sa_v.delete();
    done_t.delete();
    ack_t.delete();
    ovr_t.delete();
    bfall_t.delete();
    rise_t = 0;
    fall_t = 0;
  endtask

  task automatic chk_all_zero(input string id);
    chk({id, ".start_sending"}, start_sending, 0);
    chk({id, ".startaddr"}, startaddr, 0);
    chk({id, ".txid"}, txid, 0);
    chk({id, ".in_sending"}, in_sending, 0);
    chk({id, ".burst_done"}, burst_done, 0);
    chk({id, ".overrun"}, overrun, 0);
    chk({id, ".ack_err"}, ack_err, 0);
  endtask

  // Arm one burst, then drop enable and scramble redundancy/lastaddr once it is running.
  task automatic launch(input int r, input int la, input int h, input int gs);
    bit got;
    gap_sel    = 2'(gs);
    redundancy = 3'(r);
    lastaddr   = AddrW'(la);
    gen_h      = h;
    tick();
    tick();
    clear_log();
    enable = 1'b1;
    got    = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = (rise_t != 0);
    end
    chk("launch", got, 1);
    enable     = 1'b0;
    redundancy = 3'($urandom);
    lastaddr   = AddrW'($urandom);
  endtask

  task automatic finish_burst();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      tick();
      got = (done_t.size() > 0);
    end
    chk("done_wait", got, 1);
    repeat (4) tick();
  endtask

  task automatic check_burst(input string id, input int n, input int la, input int h,
                             input int gs);
    int g;
    int exp_sa;
    int exp_ovr;
    g      = gap_of(gs);
    exp_sa = (la >= Wrap) ? 0 : la;
    chk({id, ".starts"}, start_t.size(), n);
    chk({id, ".done_cnt"}, done_t.size(), 1);
    chk({id, ".ack_cnt"}, ack_t.size(), (h == 0) ? n : 0);
    for (int i = 0; i < start_t.size() && i < n; i++) begin
      chk($sformatf("%s.txid%0d", id, i), txid_v[i], i + 1);
      chk($sformatf("%s.addr%0d", id, i), sa_v[i], exp_sa);
      if (i > 0) begin
        chk_range($sformatf("%s.pulse_gap%0d", id, i), start_t[i] - start_t[i-1], g + 1,
                  1000000);
        if (h > 0 && bfall_t.size() >= i)
          chk_range($sformatf("%s.busy_to_start%0d", id, i), start_t[i] - bfall_t[i-1],
                    g + 1, g + 4);
      end
      if (h == 0 && ack_t.size() > i)
        chk($sformatf("%s.ack_delay%0d", id, i), ack_t[i] - start_t[i], AckTo);
    end
    if (done_t.size() > 0 && start_t.size() > 0) begin
      chk({id, ".done_after_last"}, done_t[0] > start_t[start_t.size()-1], 1);
      chk({id, ".done_at_fall"}, done_t[0], fall_t);
    end
    // Expiries fall on multiples of Period; each one seen while active is an overrun.
    exp_ovr = (fall_t - 1) / Period - (rise_t - 1) / Period;
    chk({id, ".overruns"}, ovr_t.size(), exp_ovr);
  endtask

  initial begin
    int  r;
    int  h;
    int  la;
    bit  got;
    checks     = 0;
    errors     = 0;
    rstb       = 1'b0;
    enable     = 1'b0;
    rate_sel   = 4'd15;
    gap_sel    = 2'd0;
    redundancy = 3'd0;
    busy       = 1'b0;
    lastaddr   = '0;
    gen_h      = 0;
    busy_left  = 0;
    c          = 0;
    prev_ins   = 1'b0;
    clear_log();

    repeat (4) tick();
    chk_all_zero("reset");
    rstb = 1'b1;
    c    = 0;

    launch(3, 100, 20, 0);
    finish_burst();
    check_burst("red3", 3, 100, 20, 0);

    launch(0, 5000, 10, 0);
    finish_burst();
    check_burst("red0", 1, 5000, 10, 0);

    launch(1, 57599, 5, 0);
    finish_burst();
    check_burst("wrap_below", 1, 57599, 5, 0);

    launch(2, 57600, 5, 0);
    finish_burst();
    check_burst("wrap_at", 2, 57600, 5, 0);

    launch(2, 300, 0, 0);
    finish_burst();
    check_burst("no_ack", 2, 300, 0, 0);

    launch(2, 7, 200, 0);
    finish_burst();
    check_burst("overrun", 2, 7, 200, 0);
    chk("overrun.seen", ovr_t.size() > 0, 1);

    launch(2, 1234, 3, 1);
    finish_burst();
    check_burst("gap1", 2, 1234, 3, 1);

    for (int k = 0; k < 6; k++) begin
      r = int'($urandom_range(0, 7));
      h = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 40));
      case ($urandom_range(0, 3))
        0:       la = 57599;
        1:       la = 57600;
        2:       la = int'($urandom_range(0, 57599));
        default: la = int'($urandom_range(57600, (1 << AddrW) - 1));
      endcase
      launch(r, la, h, 0);
      finish_burst();
      check_burst($sformatf("rnd%0d", k), (r == 0) ? 1 : r, la, h, 0);
    end

    // Reset while the first copy is being transmitted.
    launch(3, 4242, 20, 0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      got = (start_t.size() > 0);
    end
    chk("mid_rst.first_start", got, 1);
    repeat (3) tick();
    rstb = 1'b0;
    tick();
    chk_all_zero("mid_rst");
    rstb       = 1'b1;
    c          = 0;
    busy       = 1'b0;
    busy_left  = 0;
    redundancy = 3'd2;
    lastaddr   = AddrW'(99);
    clear_log();
    enable = 1'b1;
    got    = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = (rise_t != 0);
    end
    chk("post_rst.launch", got, 1);
    enable = 1'b0;
    finish_burst();
    chk("post_rst.rise_after_expiry", rise_t > Period, 1);
    if (start_t.size() > 0) chk("post_rst.start_after_expiry", start_t[0] > Period, 1);
    check_burst("post_rst", 2, 99, 20, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_send_scheduler.md
TX_SEND_SCHEDULER -- requirements
Module: tx_send_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, width of the frame start/last address.
REQ-002 SHALL have parameter WRAP_ADDR, default 57600, the address at or above which the next burst restarts at 0.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15, the maximum number of cycles to wait for busy to rise after a start pulse.
REQ-004 SHALL have port clk, input, 1 bit: the single 125 MHz clock; all logic is on its rising edge.
REQ-005 SHALL have port rstb, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: when low, no new burst starts.
REQ-007 SHALL have port rate_sel, input, 4 bits: selects the burst period.
REQ-008 SHALL have port gap_sel, input, 2 bits: selects the gap between copies.
REQ-009 SHALL have port redundancy, input, 3 bits: copies per burst; 0 is treated as 1.
REQ-010 SHALL have port busy, input, 1 bit: frame generator busy.
REQ-011 SHALL have port lastaddr, input, ADDR_W bits: the frame generator's end address.
REQ-012 SHALL have port start_sending, output, 1 bit: one-cycle start pulse to the frame generator.
REQ-013 SHALL have port startaddr, output, ADDR_W bits: start address for the current burst.
REQ-014 SHALL have port txid, output, 8 bits: 1-based copy index within the burst.
REQ-015 SHALL have port in_sending, output, 1 bit: high while a burst is active.
REQ-016 SHALL have port burst_done, output, 1 bit: one-cycle pulse after the last copy completes.
REQ-017 SHALL have port overrun, output, 1 bit: one-cycle pulse when the period expires while a burst is active.
REQ-018 SHALL have port ack_err, output, 1 bit: one-cycle pulse when busy fails to rise within ACK_TIMEOUT cycles.

Function
REQ-019 SHALL run a 27-bit period counter continuously from 0 to max_count, then wrap to 0 and assert an internal expiry strobe for one cycle.
REQ-020 SHALL derive max_count from rate_sel as follows:
- rate_sel 0..14 map to 125e6/P-1 for P = 1, 2, 10, 20, 50, 100, 200, 500, 1k, 2k, 5k, 10k, 20k, 50k, 100k.
- rate_sel 15 maps to 30.
- rate_sel is registered once per cycle.
REQ-021 SHALL derive max_gap from gap_sel: 0 -> 30, 1 -> 1249, 2 -> 12499, 3 -> 124999 (17-bit).
REQ-022 SHALL implement the FSM states IDLE, GAP, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-023 SHALL, in IDLE, on expiry with enable=1 and busy=0, perform all of the following:
- latch N = max(redundancy, 1);
- set startaddr to 0 if lastaddr >= WRAP_ADDR, otherwise to lastaddr;
- clear the copy counter and gap counter;
- assert in_sending and enter GAP.
REQ-024 SHALL, in IDLE on expiry with busy=1 or enable=0, skip that period without pulsing overrun.
REQ-025 SHALL, in GAP, increment the gap counter each cycle and enter ISSUE once the gap counter >= max_gap and busy=0.
REQ-026 SHALL, in ISSUE, drive start_sending=1 for exactly one cycle, increment the copy counter, set txid to the new copy count, and enter WAIT_ACK.
REQ-027 SHALL, in WAIT_ACK, enter WAIT_DONE on busy=1.
REQ-028 SHALL, in WAIT_ACK, pulse ack_err and proceed as if the copy had completed when ACK_TIMEOUT cycles elapse without busy.
REQ-029 SHALL, in WAIT_DONE, on busy=0:
- if copy counter == N: enter IDLE, deassert in_sending, pulse burst_done;
- otherwise: clear the gap counter and enter GAP.
REQ-030 SHALL pulse overrun on expiry in any state other than IDLE, leave the active burst undisturbed, and not queue the missed period.
REQ-031 SHALL hold startaddr and txid stable from burst start until the next burst updates them, so txid==1 identifies the first copy.
REQ-032 SHALL NOT affect the latched N if redundancy changes during a burst.
REQ-033 SHALL NOT affect a burst in progress if enable falls during it; the burst completes.
REQ-034 SHALL drive all outputs from registers.
REQ-035 SHALL produce at most one start_sending pulse per copy, with at least max_gap+1 cycles between consecutive pulses.

Reset
REQ-036 SHALL, on rstb=0 at a clock edge, return to IDLE and clear the period, gap and copy counters.
REQ-037 SHALL, on reset, drive start_sending=0, startaddr=0, txid=0, in_sending=0, burst_done=0, overrun=0, ack_err=0.
REQ-038 SHALL abort any burst in progress on reset mid-burst, with no further start pulses until a fresh expiry after reset release.

Structure
REQ-039 SHALL place the rate table, gap table, FSM state encoding, WAIT_ADDR default and counter widths in a shared package tx_sched_pkg.
REQ-040 SHALL implement the rate_sel/gap_sel-to-limit lookup as one registered sub-module, tx_rate_table; all else is flat.

Verification
REQ-041 SHALL check: rate_sel=15, gap_sel=0, redundancy=3, busy held high 20 cycles after each start -> three start pulses with txid 1, 2, 3, pulse spacing >= 31 cycles after busy falls, then one burst_done.
REQ-042 SHALL check: redundancy=0 -> exactly one start pulse per period, txid=1.
REQ-043 SHALL check startaddr wrap: lastaddr=57599 at burst start -> startaddr=57599; lastaddr=57600 -> startaddr=0.
REQ-044 SHALL check: busy never rises after a start -> ack_err pulses after 15 cycles, the next copy still issues, and burst_done follows the last copy.
REQ-045 SHALL check: rate_sel=15 with busy held 200 cycles per copy -> overrun pulses and no extra start pulses.
REQ-046 SHALL check: rstb=0 for one cycle during WAIT_DONE -> all outputs 0 next cycle, and no start_sending until a new expiry.
